// File: rtl/pipeline_flush_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_flush_ctrl_pkg
// Shared definitions for the pipeline flush/stall controller:
//   - halt_state_t : 2-bit debug-halt FSM state encoding
//   - DEF_*        : default stage count, flush depths and drain timeout
//   - DRAIN_CNT_W  : width of the drain timeout counter
// Optional feature macro used by the importing files: DEBUG_HALT_EN
// -----------------------------------------------------------------------------
package pipeline_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } halt_state_t;

    localparam int DEF_N_STAGES          = 4;
    localparam int DEF_BR_FLUSH_DEPTH    = 2;
    localparam int DEF_FENCE_FLUSH_DEPTH = 3;
    localparam int DEF_DRAIN_MAX         = 15;
    localparam int DRAIN_CNT_W           = 4;

endpackage

// File: rtl/pipeline_flush_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// debug_halt_fsm
// Debug halt sequencer: RUN -> DRAIN -> HALTED -> RESUME -> RUN, with a drain
// timeout counter. Only instantiated when DEBUG_HALT_EN is defined.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   halt_req_i          debug halt request (honoured only in RUN)
//   resume_req_i        debug resume request (honoured only in HALTED)
//   sys_jump_i          trap/xRET redirect; restarts the drain count
//   stage_valid_i       per-stage valid; stages 2.. must empty before halting
//   flush0_o, flush1_o  flush requests for Fetch / Decode
//   stall_all_o         hold every stage (HALTED)
//   halted_o            core halted
//   halt_pc_sel_o       PCU selects the debug halt address
//   resume_pc_sel_o     PCU selects saved dpc
// -----------------------------------------------------------------------------
module debug_halt_fsm
    import pipeline_flush_ctrl_pkg::*;
#(
    parameter int N_STAGES  = DEF_N_STAGES,
    parameter int DRAIN_MAX = DEF_DRAIN_MAX
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                halt_req_i,
    input  logic                resume_req_i,
    input  logic                sys_jump_i,
    input  logic [N_STAGES-1:0] stage_valid_i,
    output logic                flush0_o,
    output logic                flush1_o,
    output logic                stall_all_o,
    output logic                halted_o,
    output logic                halt_pc_sel_o,
    output logic                resume_pc_sel_o
);

    halt_state_t            state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic                   halted_q;
    logic                   resume_q;
    logic                   pipe_empty;
    logic                   drain_timeout;
    logic [1:0]             unused_front_valid;

    // Fetch and Decode are being flushed during the drain, so only the back
    // end has to empty out.
    assign pipe_empty         = ~|stage_valid_i[N_STAGES-1:2];
    assign unused_front_valid = stage_valid_i[1:0];
    // The comparison is against DRAIN_MAX-1 so that exactly DRAIN_MAX cycles
    // are spent in DRAIN before a forced halt.
    assign drain_timeout      = (drain_cnt == DRAIN_CNT_W'(DRAIN_MAX - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted_q  <= 1'b0;
            resume_q  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req_i) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // A redirect refills the pipe, so the timeout starts over
                    // while the halt stays pending.
                    if (sys_jump_i) begin
                        drain_cnt <= '0;
                    end else if (pipe_empty || drain_timeout) begin
                        state     <= ST_HALTED;
                        drain_cnt <= '0;
                        halted_q  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (resume_req_i) begin
                        state    <= ST_RESUME;
                        halted_q <= 1'b0;
                        resume_q <= 1'b1;
                    end
                end
                ST_RESUME: begin
                    state    <= ST_RUN;
                    resume_q <= 1'b0;
                end
                default: begin
                    state    <= ST_RUN;
                    halted_q <= 1'b0;
                    resume_q <= 1'b0;
                end
            endcase
        end
    end

    // The halt-entry flush and PC select must act in the request cycle, so
    // they are decoded from the registered state plus the request.
    assign halt_pc_sel_o   = (state == ST_RUN) & halt_req_i;
    assign flush0_o        = halt_pc_sel_o | (state == ST_DRAIN) | resume_q;
    assign flush1_o        = (state == ST_DRAIN);
    assign stall_all_o     = halted_q;
    assign halted_o        = halted_q;
    assign resume_pc_sel_o = resume_q;

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_flush_ctrl
// Combinational per-stage flush/stall generation for an N_STAGES in-order
// pipeline (stage 0 = Fetch, N_STAGES-1 = Writeback), plus an optional debug
// halt sequencer (debug_halt_fsm), compiled only with `define DEBUG_HALT_EN.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-low reset
//   branch_taken_i/hit_i/mispredict_i execute-stage branch status
//   is_fencei_i                      fence.i in execute
//   sys_jump_i                       trap or xRET redirect (flushes all)
//   unsupported_instr_i              illegal instruction in decode
//   load_hazard_i                    load-use hazard from decode
//   stall_req_i[N]                   per-stage multi-cycle stall requests
//   stage_valid_i[N]                 per-stage valid (used by the drain)
//   debug_halt_req_i/resume_req_i    debug module requests
//   flush_o[N], stall_o[N]           per-stage flush / hold
//   data_hazard_o                    load-use stall of PCU and Fetch
//   halted_o, halt_pc_sel_o, resume_pc_sel_o  debug status / PC selects
// -----------------------------------------------------------------------------
module pipeline_flush_ctrl
    import pipeline_flush_ctrl_pkg::*;
#(
    parameter int N_STAGES          = DEF_N_STAGES,
    parameter int BR_FLUSH_DEPTH    = DEF_BR_FLUSH_DEPTH,
    parameter int FENCE_FLUSH_DEPTH = DEF_FENCE_FLUSH_DEPTH,
    parameter int DRAIN_MAX         = DEF_DRAIN_MAX
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                branch_taken_i,
    input  logic                branch_hit_i,
    input  logic                branch_mispredict_i,
    input  logic                is_fencei_i,
    input  logic                sys_jump_i,
    input  logic                unsupported_instr_i,
    input  logic                load_hazard_i,
    input  logic [N_STAGES-1:0] stall_req_i,
    input  logic [N_STAGES-1:0] stage_valid_i,
    input  logic                debug_halt_req_i,
    input  logic                debug_resume_req_i,
    output logic [N_STAGES-1:0] flush_o,
    output logic [N_STAGES-1:0] stall_o,
    output logic                data_hazard_o,
    output logic                halted_o,
    output logic                halt_pc_sel_o,
    output logic                resume_pc_sel_o
);

    logic                branch_flush;
    logic [N_STAGES-1:0] stall_eff;
    logic [N_STAGES-1:0] bubble;
    logic [N_STAGES-1:0] base_flush;
    logic                dbg_flush0;
    logic                dbg_flush1;
    logic                dbg_stall_all;
    logic                dbg_halted;
    logic                dbg_halt_pc_sel;
    logic                dbg_resume_pc_sel;

    assign branch_flush = (branch_taken_i & ~branch_hit_i) | branch_mispredict_i;

`ifdef DEBUG_HALT_EN
    debug_halt_fsm #(
        .N_STAGES  (N_STAGES),
        .DRAIN_MAX (DRAIN_MAX)
    ) u_debug_halt_fsm (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .halt_req_i      (debug_halt_req_i),
        .resume_req_i    (debug_resume_req_i),
        .sys_jump_i      (sys_jump_i),
        .stage_valid_i   (stage_valid_i),
        .flush0_o        (dbg_flush0),
        .flush1_o        (dbg_flush1),
        .stall_all_o     (dbg_stall_all),
        .halted_o        (dbg_halted),
        .halt_pc_sel_o   (dbg_halt_pc_sel),
        .resume_pc_sel_o (dbg_resume_pc_sel)
    );
`else
    logic unused_debug;

    assign dbg_flush0        = 1'b0;
    assign dbg_flush1        = 1'b0;
    assign dbg_stall_all     = 1'b0;
    assign dbg_halted        = 1'b0;
    assign dbg_halt_pc_sel   = 1'b0;
    assign dbg_resume_pc_sel = 1'b0;
    assign unused_debug      = debug_halt_req_i | debug_resume_req_i |
                               (|stage_valid_i) | clk_i;
`endif

    always_comb begin
        stall_eff  = '0;
        bubble     = '0;
        base_flush = '0;
        // A stall anywhere downstream backs up every earlier stage.
        for (int k = 0; k < N_STAGES; k++) begin
            stall_eff[k] = (|(stall_req_i >> k)) | dbg_stall_all;
        end
        // The first non-stalled stage behind a stalled one gets a bubble.
        for (int k = 0; k < N_STAGES - 1; k++) begin
            bubble[k+1] = stall_eff[k] & ~stall_eff[k+1];
        end
        for (int k = 0; k < N_STAGES; k++) begin
            base_flush[k] = (is_fencei_i && (k < FENCE_FLUSH_DEPTH)) ||
                            (branch_flush && (k < BR_FLUSH_DEPTH));
        end
        base_flush[0] = base_flush[0] | dbg_flush0;
        base_flush[1] = base_flush[1] | dbg_flush1 | load_hazard_i | unsupported_instr_i;
    end

    // Outputs are forced low while reset is held, even though most of them
    // are combinational functions of the inputs.
    always_comb begin
        flush_o         = '0;
        stall_o         = '0;
        data_hazard_o   = 1'b0;
        halted_o        = 1'b0;
        halt_pc_sel_o   = 1'b0;
        resume_pc_sel_o = 1'b0;
        if (rst_i) begin
            if (sys_jump_i) begin
                flush_o = '1;
            end else begin
                flush_o = base_flush | bubble;
                stall_o = stall_eff;
            end
            data_hazard_o   = load_hazard_i & ~sys_jump_i & ~branch_flush;
            halted_o        = dbg_halted;
            halt_pc_sel_o   = dbg_halt_pc_sel;
            resume_pc_sel_o = dbg_resume_pc_sel;
        end
    end

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
module tb_pipeline_flush_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       branch_taken_i, branch_hit_i, branch_mispredict_i;
    logic       is_fencei_i, sys_jump_i, unsupported_instr_i, load_hazard_i;
    logic [3:0] stall_req_i, stage_valid_i;
    logic       debug_halt_req_i, debug_resume_req_i;
    logic [3:0] flush_o, stall_o;
    logic       data_hazard_o, halted_o, halt_pc_sel_o, resume_pc_sel_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    pipeline_flush_ctrl dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .branch_taken_i      (branch_taken_i),
        .branch_hit_i        (branch_hit_i),
        .branch_mispredict_i (branch_mispredict_i),
        .is_fencei_i         (is_fencei_i),
        .sys_jump_i          (sys_jump_i),
        .unsupported_instr_i (unsupported_instr_i),
        .load_hazard_i       (load_hazard_i),
        .stall_req_i         (stall_req_i),
        .stage_valid_i       (stage_valid_i),
        .debug_halt_req_i    (debug_halt_req_i),
        .debug_resume_req_i  (debug_resume_req_i),
        .flush_o             (flush_o),
        .stall_o             (stall_o),
        .data_hazard_o       (data_hazard_o),
        .halted_o            (halted_o),
        .halt_pc_sel_o       (halt_pc_sel_o),
        .resume_pc_sel_o     (resume_pc_sel_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        branch_taken_i      = 1'b0;
        branch_hit_i        = 1'b0;
        branch_mispredict_i = 1'b0;
        is_fencei_i         = 1'b0;
        sys_jump_i          = 1'b0;
        unsupported_instr_i = 1'b0;
        load_hazard_i       = 1'b0;
        stall_req_i         = 4'b0000;
        stage_valid_i       = 4'b0000;
        debug_halt_req_i    = 1'b0;
        debug_resume_req_i  = 1'b0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b0;
        sys_jump_i  = 1'b1;
        stall_req_i = 4'b1111;
        load_hazard_i = 1'b1;
        #1;
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_dhaz", 32'(data_hazard_o), 32'h0);
        chk("rst_halted", 32'(halted_o), 32'h0);
        step();
        step();
        rst_i = 1'b1;
        clear_inputs();

        step(); #1;
        chk("idle_flush", 32'(flush_o), 32'h0);
        chk("idle_stall", 32'(stall_o), 32'h0);

        step(); branch_mispredict_i = 1'b1; #1;
        chk("mispredict_flush", 32'(flush_o), 32'h3);
        chk("mispredict_stall", 32'(stall_o), 32'h0);

        step(); clear_inputs(); branch_taken_i = 1'b1; #1;
        chk("taken_nohit_flush", 32'(flush_o), 32'h3);
        branch_hit_i = 1'b1; #1;
        chk("taken_hit_flush", 32'(flush_o), 32'h0);

        step(); clear_inputs(); is_fencei_i = 1'b1; #1;
        chk("fencei_flush", 32'(flush_o), 32'h7);

        step(); clear_inputs(); load_hazard_i = 1'b1; #1;
        chk("ldhaz_flush", 32'(flush_o), 32'h2);
        chk("ldhaz_dhaz", 32'(data_hazard_o), 32'h1);
        branch_mispredict_i = 1'b1; #1;
        chk("ldhaz_br_dhaz", 32'(data_hazard_o), 32'h0);
        chk("ldhaz_br_flush", 32'(flush_o), 32'h3);

        step(); clear_inputs(); unsupported_instr_i = 1'b1; #1;
        chk("illegal_flush", 32'(flush_o), 32'h2);
        chk("illegal_dhaz", 32'(data_hazard_o), 32'h0);

        step(); clear_inputs(); stall_req_i = 4'b0100; #1;
        chk("stall2_stall", 32'(stall_o), 32'h7);
        chk("stall2_flush", 32'(flush_o), 32'h8);

        step(); stall_req_i = 4'b1111; #1;
        chk("stallall_stall", 32'(stall_o), 32'hF);
        chk("stallall_flush", 32'(flush_o), 32'h0);

        step(); stall_req_i = 4'b0001; #1;
        chk("stall0_stall", 32'(stall_o), 32'h1);
        chk("stall0_flush", 32'(flush_o), 32'h2);

        step(); stall_req_i = 4'b0010; branch_mispredict_i = 1'b1; #1;
        chk("stall1_br_stall", 32'(stall_o), 32'h3);
        chk("stall1_br_flush", 32'(flush_o), 32'h7);

        step(); clear_inputs(); sys_jump_i = 1'b1; stall_req_i = 4'b1111; load_hazard_i = 1'b1; #1;
        chk("sysjump_flush", 32'(flush_o), 32'hF);
        chk("sysjump_stall", 32'(stall_o), 32'h0);
        chk("sysjump_dhaz", 32'(data_hazard_o), 32'h0);

`ifdef DEBUG_HALT_EN
        // Drain ending on empty back end: request in cycle 1, halted in cycle 5.
        step(); clear_inputs(); debug_halt_req_i = 1'b1; stage_valid_i = 4'b1100; #1;
        chk("halt_req_flush", 32'(flush_o), 32'h1);
        chk("halt_req_pcsel", 32'(halt_pc_sel_o), 32'h1);
        step(); debug_halt_req_i = 1'b0; #1;
        chk("drain_c2_flush", 32'(flush_o), 32'h3);
        chk("drain_c2_pcsel", 32'(halt_pc_sel_o), 32'h0);
        step(); #1;
        chk("drain_c3_halted", 32'(halted_o), 32'h0);
        step(); stage_valid_i = 4'b0000; #1;
        chk("drain_c4_halted", 32'(halted_o), 32'h0);
        step(); #1;
        chk("halted_c5", 32'(halted_o), 32'h1);
        chk("halted_stall", 32'(stall_o), 32'hF);
        debug_halt_req_i = 1'b1; #1;
        chk("halted_ignore_req", 32'(halt_pc_sel_o), 32'h0);
        step(); debug_halt_req_i = 1'b0; debug_resume_req_i = 1'b1; #1;
        chk("resume_req_halted", 32'(halted_o), 32'h1);
        step(); debug_resume_req_i = 1'b0; #1;
        chk("resume_pcsel", 32'(resume_pc_sel_o), 32'h1);
        chk("resume_flush", 32'(flush_o), 32'h1);
        chk("resume_halted", 32'(halted_o), 32'h0);
        step(); #1;
        chk("run_pcsel", 32'(resume_pc_sel_o), 32'h0);
        chk("run_stall", 32'(stall_o), 32'h0);

        // Drain timeout: back end never empties.
        step(); debug_halt_req_i = 1'b1; stage_valid_i = 4'b1000; #1;
        chk("to_req_pcsel", 32'(halt_pc_sel_o), 32'h1);
        for (int i = 1; i <= 15; i++) begin
            step(); debug_halt_req_i = 1'b0; #1;
            if (i == 15) chk("to_drain15_halted", 32'(halted_o), 32'h0);
        end
        step(); #1;
        chk("to_halted", 32'(halted_o), 32'h1);
        step(); debug_resume_req_i = 1'b1;
        step(); debug_resume_req_i = 1'b0;
        step(); #1;
        chk("to_back_run", 32'(flush_o), 32'h0);

        // Reset in the middle of a drain abandons the halt.
        step(); debug_halt_req_i = 1'b1; stage_valid_i = 4'b1000;
        step(); debug_halt_req_i = 1'b0;
        step(); rst_i = 1'b0; #1;
        chk("rstdrain_flush", 32'(flush_o), 32'h0);
        chk("rstdrain_stall", 32'(stall_o), 32'h0);
        chk("rstdrain_halted", 32'(halted_o), 32'h0);
        step(); rst_i = 1'b1; stage_valid_i = 4'b0000; #1;
        chk("rstdrain_rel_flush", 32'(flush_o), 32'h0);
        step(); #1;
        chk("rstdrain_rel_halted", 32'(halted_o), 32'h0);
`else
        // Without the debug feature the debug inputs have no effect.
        step(); clear_inputs(); debug_halt_req_i = 1'b1; stage_valid_i = 4'b1100; #1;
        chk("nodbg_halt_pcsel", 32'(halt_pc_sel_o), 32'h0);
        chk("nodbg_halt_flush", 32'(flush_o), 32'h0);
        step(); #1;
        chk("nodbg_halted", 32'(halted_o), 32'h0);
        chk("nodbg_stall", 32'(stall_o), 32'h0);
        step(); debug_halt_req_i = 1'b0; debug_resume_req_i = 1'b1; #1;
        chk("nodbg_resume_pcsel", 32'(resume_pc_sel_o), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
